latrsnq_stim_chk: RTL and testbench

Self-checking stimulus driver for the active-low reset/set latch cell (latrsnq family): the driving end of the latch's E/D/RN/SETN pin interface. On START it forces the latch to a known state, then applies a pseudo-random sequence of pin vectors. After each vector it samples the latch output Q and compares it against an internal reference model. It sits in the cell-library silicon/bench characterization harness, one instance per latch under test, and reports pass/fail plus an error count.

---
 rtl/latrsnq_stim_chk.sv | 180 ++++++++++++++++++
 tb/tb_latrsnq_stim_chk.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/latrsnq_stim_chk.sv
// Stimulus driver and checker for one active-low reset/set latch (latrsnq family).
// Optional build macro LATRSNQ_STIM_CHK_STOP_ON_FAIL_EN: end the run at the first mismatch.
module latrsnq_stim_chk #(
    parameter int         NVEC   = 16,
    parameter int         SETTLE = 2,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_q_in,
    output logic       o_e_out,
    output logic       o_d_out,
    output logic       o_rn_out,
    output logic       o_setn_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fail,
    output logic [7:0] o_err_cnt,
    output logic [7:0] o_fail_idx,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_DRIVE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX  = 8'(NVEC - 1);
    localparam logic [3:0] INIT_LAST = 4'(SETTLE);
    localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_lfsr;
    logic [7:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_model;
    logic       r_e;
    logic       r_d;
    logic       r_rn;
    logic       r_setn;
    logic       r_fail;
    logic [7:0] r_err_cnt;
    logic [7:0] r_fail_idx;

    // Reset/set are ORed pairs so they are mostly inactive, giving the data path exercise.
    logic w_vec_rn;
    logic w_vec_setn;
    logic w_vec_e;
    logic w_vec_d;
    logic w_model_next;
    logic w_mismatch;
    logic w_last;

    assign w_vec_rn   = r_lfsr[7] | r_lfsr[6];
    assign w_vec_setn = r_lfsr[5] | r_lfsr[4];
    assign w_vec_e    = r_lfsr[1];
    assign w_vec_d    = r_lfsr[0];
    assign w_mismatch = (i_q_in != r_model);
    assign w_last     = (r_idx == LAST_IDX);

    always_comb begin
        w_model_next = r_model;
        if (!w_vec_rn)        w_model_next = 1'b0;
        else if (!w_vec_setn) w_model_next = 1'b1;
        else if (w_vec_e)     w_model_next = w_vec_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_INIT;
            S_INIT:  if (r_cnt == INIT_LAST) w_state_next = S_DRIVE;
            S_DRIVE: w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == WAIT_LAST) w_state_next = S_CHECK;
            S_CHECK: begin
`ifdef LATRSNQ_STIM_CHK_STOP_ON_FAIL_EN
                if (w_last || w_mismatch) w_state_next = S_FIN;
`else
                if (w_last) w_state_next = S_FIN;
`endif
                else w_state_next = S_DRIVE;
            end
            S_FIN:   if (i_start) w_state_next = S_INIT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_INIT, S_DRIVE, S_WAIT, S_CHECK: o_busy = 1'b1;
            S_FIN:                            o_done = 1'b1;
            default:                          ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr     <= SEED_EFF;
            r_idx      <= 8'd0;
            r_cnt      <= 4'd0;
            r_model    <= 1'b0;
            r_e        <= 1'b0;
            r_d        <= 1'b0;
            r_rn       <= 1'b1;
            r_setn     <= 1'b1;
            r_fail     <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_fail_idx <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (i_start) begin
                        r_lfsr     <= SEED_EFF;
                        r_idx      <= 8'd0;
                        r_cnt      <= 4'd0;
                        r_model    <= 1'b0;
                        r_e        <= 1'b0;
                        r_rn       <= 1'b0;
                        r_setn     <= 1'b1;
                        r_fail     <= 1'b0;
                        r_err_cnt  <= 8'd0;
                        r_fail_idx <= 8'd0;
                    end
                end
                S_INIT: r_cnt <= r_cnt + 4'd1;
                S_DRIVE: begin
                    r_rn    <= w_vec_rn;
                    r_setn  <= w_vec_setn;
                    r_e     <= w_vec_e;
                    r_d     <= w_vec_d;
                    r_model <= w_model_next;
                    r_cnt   <= 4'd0;
                end
                S_WAIT: r_cnt <= r_cnt + 4'd1;
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        if (!r_fail) begin
                            r_fail     <= 1'b1;
                            r_fail_idx <= r_idx;
                        end
                    end
                    r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                    if (w_state_next == S_DRIVE) r_idx <= r_idx + 8'd1;
                    // Release the latch into hold as the run ends; D keeps its last value.
                    if (w_state_next == S_FIN) begin
                        r_e    <= 1'b0;
                        r_rn   <= 1'b1;
                        r_setn <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_e_out    = r_e;
    assign o_d_out    = r_d;
    assign o_rn_out   = r_rn;
    assign o_setn_out = r_setn;
    assign o_fail     = r_fail;
    assign o_err_cnt  = r_err_cnt;
    assign o_fail_idx = r_fail_idx;
    assign o_state    = r_state;

endmodule

// File: tb/tb_latrsnq_stim_chk.sv
// Directed bench for latrsnq_stim_chk: default instance plus a SETTLE=1/NVEC=2/SEED=0 instance.
module tb_latrsnq_stim_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_b = 1'b0;
    logic start_s = 1'b0;
    logic q_b = 1'b0;
    logic q_s = 1'b0;
    int   mode_b = 0;  // 0 ideal, 1 stuck 0, 2 set-over-reset, 3 stuck 1
    int   mode_s = 0;

    logic e_b, d_b, rn_b, setn_b, busy_b, done_b, fail_b;
    logic [7:0] err_b, fidx_b;
    logic [2:0] st_b;
    logic e_s, d_s, rn_s, setn_s, busy_s, done_s, fail_s;
    logic [7:0] err_s, fidx_s;
    logic [2:0] st_s;

    int checks = 0;
    int errors = 0;
    logic [3:0] pins_h [0:255];  // {e, d, rn, setn} per cycle
    logic       busy_h [0:255];

    latrsnq_stim_chk u_big (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_q_in(q_b),
        .o_e_out(e_b), .o_d_out(d_b), .o_rn_out(rn_b), .o_setn_out(setn_b),
        .o_busy(busy_b), .o_done(done_b), .o_fail(fail_b),
        .o_err_cnt(err_b), .o_fail_idx(fidx_b), .o_state(st_b)
    );

    latrsnq_stim_chk #(.NVEC(2), .SETTLE(1), .SEED(8'h00)) u_small (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_q_in(q_s),
        .o_e_out(e_s), .o_d_out(d_s), .o_rn_out(rn_s), .o_setn_out(setn_s),
        .o_busy(busy_s), .o_done(done_s), .o_fail(fail_s),
        .o_err_cnt(err_s), .o_fail_idx(fidx_s), .o_state(st_s)
    );

    // Behavioural latches under test.
    always @* begin
        case (mode_b)
            0: if (!rn_b) q_b = 1'b0; else if (!setn_b) q_b = 1'b1; else if (e_b) q_b = d_b;
            1: q_b = 1'b0;
            2: if (!setn_b) q_b = 1'b1; else if (!rn_b) q_b = 1'b0; else if (e_b) q_b = d_b;
            default: q_b = 1'b1;
        endcase
    end

    always @* begin
        case (mode_s)
            0: if (!rn_s) q_s = 1'b0; else if (!setn_s) q_s = 1'b1; else if (e_s) q_s = d_s;
            1: q_s = 1'b0;
            2: if (!setn_s) q_s = 1'b1; else if (!rn_s) q_s = 1'b0; else if (e_s) q_s = d_s;
            default: q_s = 1'b1;
        endcase
    end

    // Pulse START so it is sampled by exactly one edge (edge 0); returns at the negedge after it.
    task automatic do_start(input bit sel);
        @(negedge clk);
        if (sel) start_s = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        start_s = 1'b0;
    endtask

    // Counts edges after edge 0 until DONE is seen; optionally re-pulses START at cycle pulse_at.
    task automatic wait_done(input bit sel, input int pulse_at, output int n);
        bit stop;
        n = 0;
        stop = 1'b0;
        while (!stop) begin
            pins_h[n] = sel ? {e_s, d_s, rn_s, setn_s} : {e_b, d_b, rn_b, setn_b};
            busy_h[n] = sel ? busy_s : busy_b;
            if (sel ? done_s : done_b) begin
                stop = 1'b1;
            end else if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: no DONE after %0d cycles, required within 200", n);
                stop = 1'b1;
            end else begin
                if (n == pulse_at) begin
                    if (sel) start_s = 1'b1; else start_b = 1'b1;
                end
                @(posedge clk);
                n++;
                @(negedge clk);
                start_b = 1'b0;
                start_s = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({e_b, d_b, rn_b, setn_b} !== 4'b0011) begin
            errors++; $display("FAIL reset_pins_b: got %b, want 0011", {e_b, d_b, rn_b, setn_b});
        end
        checks++;
        if ({busy_b, done_b, fail_b, err_b, fidx_b, st_b} !== 22'd0) begin
            errors++; $display("FAIL reset_status_b: busy %b done %b fail %b err %0d idx %0d st %0d, want all 0",
                               busy_b, done_b, fail_b, err_b, fidx_b, st_b);
        end
        checks++;
        if ({e_s, d_s, rn_s, setn_s, busy_s, done_s, fail_s, err_s, fidx_s} !== {4'b0011, 19'd0}) begin
            errors++; $display("FAIL reset_small: pins %b busy %b done %b fail %b err %0d idx %0d",
                               {e_s, d_s, rn_s, setn_s}, busy_s, done_s, fail_s, err_s, fidx_s);
        end
        rst = 1'b0;
    endtask

    task automatic test_ideal();
        int n;
        mode_b = 0;
        do_start(1'b0);
        wait_done(1'b0, -1, n);
        checks++;
        if (n != 67) begin errors++; $display("FAIL ideal_cycles: got %0d, want 67", n); end
        checks++;
        if ({pins_h[0][1], pins_h[1][1], pins_h[2][1], busy_h[0], busy_h[1], busy_h[2]} !== 6'b000111) begin
            errors++; $display("FAIL ideal_init_rn_busy: rn %b%b%b busy %b%b%b, want rn 000 busy 111",
                               pins_h[0][1], pins_h[1][1], pins_h[2][1], busy_h[0], busy_h[1], busy_h[2]);
        end
        checks++;
        if (pins_h[4] !== 4'b0111) begin errors++; $display("FAIL ideal_vec0: got %b, want 0111", pins_h[4]); end
        checks++;
        if (pins_h[8] !== 4'b1010) begin errors++; $display("FAIL ideal_vec1: got %b, want 1010", pins_h[8]); end
        checks++;
        if ({fail_b, err_b, fidx_b} !== 17'd0) begin
            errors++; $display("FAIL ideal_result: fail %b err %0d idx %0d, want 0/0/0", fail_b, err_b, fidx_b);
        end
        checks++;
        if ({e_b, rn_b, setn_b, busy_b, st_b} !== {4'b0110, 3'd5}) begin
            errors++; $display("FAIL ideal_fin: e %b rn %b setn %b busy %b st %0d, want 0 1 1 0 5",
                               e_b, rn_b, setn_b, busy_b, st_b);
        end
    endtask

    task automatic test_stuck0();
        int n;
        int exp_n, exp_err;
`ifdef LATRSNQ_STIM_CHK_STOP_ON_FAIL_EN
        exp_n = 11; exp_err = 1;
`else
        exp_n = 67; exp_err = 8;
`endif
        mode_b = 1;
        do_start(1'b0);
        wait_done(1'b0, -1, n);
        checks++;
        if (n != exp_n) begin errors++; $display("FAIL stuck0_cycles: got %0d, want %0d", n, exp_n); end
        checks++;
        if ({fail_b, err_b, fidx_b} !== {1'b1, 8'(exp_err), 8'd1}) begin
            errors++; $display("FAIL stuck0_result: fail %b err %0d idx %0d, want 1/%0d/1",
                               fail_b, err_b, fidx_b, exp_err);
        end
    endtask

    task automatic test_stuck1_start_busy();
        int n;
        int exp_n, exp_err;
`ifdef LATRSNQ_STIM_CHK_STOP_ON_FAIL_EN
        exp_n = 7; exp_err = 1;
`else
        exp_n = 67; exp_err = 8;
`endif
        mode_b = 3;
        do_start(1'b0);
        wait_done(1'b0, 4, n);
        checks++;
        if (n != exp_n) begin errors++; $display("FAIL stuck1_cycles: got %0d, want %0d", n, exp_n); end
        checks++;
        if ({fail_b, err_b, fidx_b, done_b} !== {1'b1, 8'(exp_err), 8'd0, 1'b1}) begin
            errors++; $display("FAIL stuck1_result: fail %b err %0d idx %0d done %b, want 1/%0d/0/1",
                               fail_b, err_b, fidx_b, done_b, exp_err);
        end
    endtask

    task automatic test_swapped();
        int n;
        mode_b = 2;
        do_start(1'b0);
        wait_done(1'b0, -1, n);
        checks++;
        if (n != 67 || fail_b !== 1'b0 || err_b !== 8'd0) begin
            errors++; $display("FAIL swapped_big: cycles %0d fail %b err %0d, want 67/0/0", n, fail_b, err_b);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        mode_b = 0;
        do_start(1'b0);
        repeat (19) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({e_b, rn_b, setn_b, busy_b, done_b, st_b} !== {5'b01100, 3'd0}) begin
            errors++; $display("FAIL rst_mid: e %b rn %b setn %b busy %b done %b st %0d, want 0 1 1 0 0 0",
                               e_b, rn_b, setn_b, busy_b, done_b, st_b);
        end
        do_start(1'b0);
        wait_done(1'b0, -1, n);
        checks++;
        if (n != 67 || fail_b !== 1'b0) begin
            errors++; $display("FAIL rst_rerun: cycles %0d fail %b, want 67/0", n, fail_b);
        end
        @(negedge clk);
        start_b = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        rst = 1'b0;
        checks++;
        if ({busy_b, done_b, st_b} !== 5'd0) begin
            errors++; $display("FAIL rst_beats_start: busy %b done %b st %0d, want 0 0 0", busy_b, done_b, st_b);
        end
    endtask

    task automatic test_small();
        int n;
        int exp_n, exp_err;
        mode_s = 0;
        do_start(1'b1);
        wait_done(1'b1, -1, n);
        checks++;
        if (n != 8) begin errors++; $display("FAIL small_cycles: got %0d, want 8", n); end
        checks++;
        if (pins_h[3] !== 4'b0100 || pins_h[6] !== 4'b1000) begin
            errors++; $display("FAIL small_vectors: got %b %b, want 0100 1000", pins_h[3], pins_h[6]);
        end
        checks++;
        if (fail_s !== 1'b0 || err_s !== 8'd0) begin
            errors++; $display("FAIL small_ideal: fail %b err %0d, want 0/0", fail_s, err_s);
        end
`ifdef LATRSNQ_STIM_CHK_STOP_ON_FAIL_EN
        exp_n = 5; exp_err = 1;
`else
        exp_n = 8; exp_err = 2;
`endif
        mode_s = 2;
        do_start(1'b1);
        wait_done(1'b1, -1, n);
        checks++;
        if (n != exp_n || {fail_s, err_s, fidx_s} !== {1'b1, 8'(exp_err), 8'd0}) begin
            errors++; $display("FAIL small_swapped: cycles %0d fail %b err %0d idx %0d, want %0d/1/%0d/0",
                               n, fail_s, err_s, fidx_s, exp_n, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck0();
        test_stuck1_start_busy();
        test_swapped();
        test_rst_mid();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
